// File: rtl/dmem_arbiter_if.sv
// Data-memory arbiter bus: core port, debug port, clear control, memory side.
// The slave modport belongs to the arbiter; master is the requester/memory side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              c_req;
    logic              c_we;
    logic [3:0]        c_be;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;

    logic              m_en;
    logic              m_we;
    logic [3:0]        m_be;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  c_req, c_we, c_be, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        input  clr_start,
        output clr_busy, clr_done,
        output m_en, m_we, m_be, m_addr, m_wdata,
        input  m_rdata
    );

    modport master (
        output c_req, c_we, c_be, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        output clr_start,
        input  clr_busy, clr_done,
        input  m_en, m_we, m_be, m_addr, m_wdata,
        output m_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter (core vs debug) with a hardware clear engine.
// Core has priority; a starvation counter forces a debug slot.
module dmem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input logic          clk,
    input logic          rst,
    dmem_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    typedef enum logic {ARB, CLEAR} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [SW-1:0]     r_starve;
    logic [SW-1:0]     w_starve_nx;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_c_rvalid;
    logic              r_d_rvalid;
    logic              r_clr_done;

    logic              w_dbg_win;
    logic              w_c_gnt;
    logic              w_d_gnt;
    logic              w_clr_last;
    logic              w_m_en;
    logic              w_m_we;
    logic [3:0]        w_m_be;
    logic [ADDR_W-1:0] w_m_addr;
    logic [DATA_W-1:0] w_m_wdata;

    always_comb begin
        w_clr_last  = (r_clr_cnt == '1);
        w_dbg_win   = bus.d_req & (~bus.c_req | (r_starve == STARVE_TOP));
        w_c_gnt     = 1'b0;
        w_d_gnt     = 1'b0;
        w_next      = r_state;
        w_starve_nx = r_starve;
        w_m_en      = 1'b0;
        w_m_we      = 1'b0;
        w_m_be      = 4'h0;
        w_m_addr    = '0;
        w_m_wdata   = '0;
        unique case (r_state)
            ARB: begin
                if (!rst) begin
                    w_c_gnt = bus.c_req & ~w_dbg_win;
                    w_d_gnt = w_dbg_win;
                end
                if (w_c_gnt) begin
                    w_m_en    = 1'b1;
                    w_m_we    = bus.c_we;
                    w_m_be    = bus.c_we ? bus.c_be : 4'h0;
                    w_m_addr  = bus.c_addr;
                    w_m_wdata = bus.c_wdata;
                end else if (w_d_gnt) begin
                    w_m_en    = 1'b1;
                    w_m_we    = bus.d_we;
                    w_m_be    = bus.d_we ? bus.d_be : 4'h0;
                    w_m_addr  = bus.d_addr;
                    w_m_wdata = bus.d_wdata;
                end
                // Debug win or no debug demand resets the fairness count.
                if (w_d_gnt || !bus.d_req) begin
                    w_starve_nx = '0;
                end else if (w_c_gnt && r_starve != STARVE_TOP) begin
                    w_starve_nx = r_starve + 1'b1;
                end
                if (bus.clr_start) begin
                    w_next = CLEAR;
                end
            end
            CLEAR: begin
                w_m_en    = 1'b1;
                w_m_we    = 1'b1;
                w_m_be    = 4'hF;
                w_m_addr  = r_clr_cnt;
                if (w_clr_last) begin
                    w_next = ARB;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ARB;
            r_starve   <= '0;
            r_clr_cnt  <= '0;
            r_c_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_starve   <= w_starve_nx;
            r_clr_cnt  <= (r_state == CLEAR) ? r_clr_cnt + ADDR_W'(1) : '0;
            r_c_rvalid <= w_c_gnt & ~bus.c_we;
            r_d_rvalid <= w_d_gnt & ~bus.d_we;
            r_clr_done <= (r_state == CLEAR) & w_clr_last;
        end
    end

    assign bus.c_gnt    = w_c_gnt;
    assign bus.d_gnt    = w_d_gnt;
    assign bus.c_rvalid = r_c_rvalid;
    assign bus.d_rvalid = r_d_rvalid;
    assign bus.c_rdata  = bus.m_rdata;
    assign bus.d_rdata  = bus.m_rdata;
    assign bus.clr_busy = (r_state == CLEAR);
    assign bus.clr_done = r_clr_done;
    assign bus.m_en     = w_m_en;
    assign bus.m_we     = w_m_we;
    assign bus.m_be     = w_m_be;
    assign bus.m_addr   = w_m_addr;
    assign bus.m_wdata  = w_m_wdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed traffic, starvation,
// clear engine and reset-abort, with a 16-word synchronous memory model.
module tb_dmem_arbiter;
    localparam int AW = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [31:0] mem [16];
    logic [31:0] r_rd;

    always @(posedge clk) begin
        if (bus.m_en) begin
            if (bus.m_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.m_be[b]) mem[bus.m_addr][8*b +: 8] <= bus.m_wdata[8*b +: 8];
                end
            end else begin
                r_rd <= mem[bus.m_addr];
            end
        end
    end
    assign bus.m_rdata = r_rd;

    int checks = 0;
    int errors = 0;
    logic [31:0] c_q [$];
    logic [31:0] d_q [$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.c_rvalid) begin
            if (c_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL c_rvalid_unexpected actual=1 required=0");
            end else begin
                chk("c_rdata", bus.c_rdata, c_q.pop_front());
            end
        end
        if (bus.d_rvalid) begin
            if (d_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d_rvalid_unexpected actual=1 required=0");
            end else begin
                chk("d_rdata", bus.d_rdata, d_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.c_req = 0; bus.c_we = 0; bus.c_be = 0;
        bus.c_addr = 0; bus.c_wdata = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_be = 0;
        bus.d_addr = 0; bus.d_wdata = 0;
        bus.clr_start = 0;
    endtask

    task automatic core_op(input logic we, input logic [3:0] be,
                           input logic [3:0] a, input logic [31:0] wd,
                           input logic [31:0] exp);
        bus.c_req = 1; bus.c_we = we; bus.c_be = be;
        bus.c_addr = a; bus.c_wdata = wd;
        #1;
        chk("c_gnt", bus.c_gnt, 1);
        chk("d_gnt_idle", bus.d_gnt, 0);
        if (!we) c_q.push_back(exp);
        cyc();
        bus.c_req = 0;
        chk("c_rvalid_lat", bus.c_rvalid, !we);
    endtask

    task automatic dbg_op(input logic we, input logic [3:0] be,
                          input logic [3:0] a, input logic [31:0] wd,
                          input logic [31:0] exp);
        bus.d_req = 1; bus.d_we = we; bus.d_be = be;
        bus.d_addr = a; bus.d_wdata = wd;
        #1;
        chk("d_gnt", bus.d_gnt, 1);
        if (!we) d_q.push_back(exp);
        cyc();
        bus.d_req = 0;
        chk("d_rvalid_lat", bus.d_rvalid, !we);
    endtask

    initial begin
        logic exp_d;
        logic seen_done;
        idle();
        rst = 1;
        bus.c_req = 1;
        bus.d_req = 1;
        repeat (2) cyc();
        chk("rst_c_gnt", bus.c_gnt, 0);
        chk("rst_d_gnt", bus.d_gnt, 0);
        chk("rst_clr_busy", bus.clr_busy, 0);
        chk("rst_c_rvalid", bus.c_rvalid, 0);
        chk("rst_clr_done", bus.clr_done, 0);
        idle();
        rst = 0;
        cyc();

        core_op(1, 4'hF, 5, 32'hDEADBEEF, 0);
        core_op(0, 4'hF, 5, 0, 32'hDEADBEEF);
        core_op(1, 4'h1, 5, 32'h000000AA, 0);
        core_op(0, 4'h0, 5, 0, 32'hDEADBEAA);
        dbg_op(1, 4'hF, 6, 32'h12345678, 0);
        dbg_op(0, 4'h0, 6, 0, 32'h12345678);

        bus.c_req = 1; bus.c_we = 0; bus.c_addr = 5;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 6;
        for (int i = 0; i < 10; i++) begin
            #1;
            exp_d = (i % 5 == 4);
            chk("starve_d_gnt", bus.d_gnt, exp_d);
            chk("starve_c_gnt", bus.c_gnt, !exp_d);
            if (exp_d) d_q.push_back(32'h12345678);
            else c_q.push_back(32'hDEADBEAA);
            cyc();
        end
        idle();
        cyc();

        for (int a = 0; a < 16; a++) core_op(1, 4'hF, a[3:0], 32'h11111111, 0);
        bus.clr_start = 1;
        #1;
        chk("clr_start_c_gnt", bus.c_gnt, 0);
        cyc();
        bus.clr_start = 0;
        bus.c_req = 1; bus.c_we = 0; bus.c_addr = 3;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 3;
        for (int i = 0; i < 16; i++) begin
            bus.clr_start = (i == 5);
            #1;
            chk("clr_busy", bus.clr_busy, 1);
            chk("clr_c_gnt", bus.c_gnt, 0);
            chk("clr_d_gnt", bus.d_gnt, 0);
            chk("clr_m_addr", bus.m_addr, i);
            chk("clr_m_we", bus.m_we, 1);
            chk("clr_m_be", bus.m_be, 4'hF);
            chk("clr_m_wdata", bus.m_wdata, 0);
            chk("clr_done_early", bus.clr_done, 0);
            cyc();
        end
        bus.clr_start = 0;
        #1;
        chk("clr_busy_end", bus.clr_busy, 0);
        chk("clr_done_pulse", bus.clr_done, 1);
        chk("post_clr_c_gnt", bus.c_gnt, 1);
        chk("post_clr_d_gnt", bus.d_gnt, 0);
        c_q.push_back(0);
        cyc();
        bus.c_req = 0;
        #1;
        chk("post_clr_d_gnt2", bus.d_gnt, 1);
        chk("clr_done_once", bus.clr_done, 0);
        d_q.push_back(0);
        cyc();
        idle();
        for (int a = 0; a < 16; a++) core_op(0, 4'h0, a[3:0], 0, 0);

        for (int a = 0; a < 16; a++) core_op(1, 4'hF, a[3:0], 32'h11111111, 0);
        bus.clr_start = 1;
        cyc();
        bus.clr_start = 0;
        repeat (7) cyc();
        #1;
        chk("abort_m_addr", bus.m_addr, 7);
        rst = 1;
        cyc();
        chk("abort_clr_busy", bus.clr_busy, 0);
        rst = 0;
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.clr_done) seen_done = 1;
            cyc();
        end
        chk("abort_no_done", seen_done, 0);
        for (int a = 8; a < 16; a++) core_op(0, 4'h0, a[3:0], 0, 32'h11111111);
        repeat (2) cyc();
        chk("c_q_drained", c_q.size(), 0);
        chk("d_q_drained", d_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single-port data memory of the RVSEED core between two requesters: the core load/store unit (port c_) and a debug/loader port (port d_).
- Contains a hardware clear engine that zeroes every memory word between test programs, replacing host-side memory reloads.
- Sits between U_DATA_MEM_0 and its users. The core normally has priority; a starvation counter guarantees forward progress for the debug port.

Parameters:
- ADDR_W, 10, word address width; memory depth DEPTH = 2^ADDR_W words.
- DATA_W, 32, data word width.
- STARVE_MAX, 4, consecutive core grants that a pending debug request tolerates before it is forced a slot.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active high.
- c_req  in  1  core request; held until granted.
- c_we  in  1  core write enable (0 = read).
- c_be  in  4  core byte enables (writes only).
- c_addr  in  ADDR_W  core word address.
- c_wdata  in  DATA_W  core write data.
- c_gnt  out  1  core grant, combinational, same cycle as the request.
- c_rvalid  out  1  core read data valid.
- c_rdata  out  DATA_W  core read data.
- d_req, d_we, d_be, d_addr, d_wdata  in  (same widths as core)  debug request signals.
- d_gnt, d_rvalid, d_rdata  out  (same widths as core)  debug response signals.
- clr_start  in  1  single-cycle pulse that starts a full memory clear.
- clr_busy  out  1  high while the clear engine owns the memory.
- clr_done  out  1  single-cycle pulse when the clear completes.
- m_en  out  1  memory enable.
- m_we  out  1  memory write enable.
- m_be  out  4  memory byte enables.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data; synchronous, valid 1 cycle after the read enable.

Behaviour:
- Reset (rst=1 at posedge):
  - state=ARB; starve_cnt=0; clr_cnt=0.
  - c_rvalid=d_rvalid=clr_done=0; clr_busy=0.
  - c_gnt=d_gnt=0 while rst is high.
  - Reset during CLEAR aborts the clear: no clr_done, memory stays partially cleared.
- FSM has two states, ARB and CLEAR.
- ARB state, grant decision (combinational):
  - dbg_win = d_req & (~c_req | starve_cnt==STARVE_MAX).
  - c_gnt = c_req & ~dbg_win; d_gnt = dbg_win.
  - At most one grant per cycle.
- ARB state, memory drive:
  - m_en = c_gnt | d_gnt.
  - m_we, m_be, m_addr, m_wdata come from the granted port; they are all-zero when nothing is granted.
  - m_be is forced to 0 on reads.
- starve_cnt, updated at posedge:
  - Increments (saturating at STARVE_MAX) when c_gnt & d_req.
  - Clears to 0 when d_gnt or ~d_req.
  - Otherwise holds.
- Read return:
  - c_rvalid <= c_gnt & ~c_we; d_rvalid <= d_gnt & ~d_we.
  - c_rdata and d_rdata both pass m_rdata through; they are meaningful only when the matching rvalid is high.
  - Read latency is 1 cycle; writes return nothing.
- ARB to CLEAR transition:
  - clr_start in ARB is sampled at posedge; the next state is CLEAR with clr_cnt=0.
  - Arbitration proceeds normally in the cycle clr_start is high; a read granted in that cycle returns its rvalid in the first CLEAR cycle.
- CLEAR state:
  - clr_busy=1; c_gnt=d_gnt=0, so requesters stall while holding req.
  - Memory drive: m_en=1, m_we=1, m_be=4'hF, m_wdata=0, m_addr=clr_cnt.
  - clr_cnt increments every cycle; starve_cnt holds.
  - clr_start is ignored.
  - When clr_cnt==DEPTH-1, that write is the last; the next state is ARB, clr_cnt returns to 0, and clr_done=1 for exactly the first cycle back in ARB.
  - A clear takes exactly DEPTH cycles.
- clr_cnt is ADDR_W bits wide and terminates on all-ones; it never wraps mid-clear.
- All outputs except the grants and the memory-drive signals are registered.

Test Plan:
- Reset, then core-only traffic: core write 0xDEADBEEF to addr 5 (be=F), then core read addr 5 → c_gnt same cycle each time; c_rvalid=1 one cycle after the read with c_rdata=0xDEADBEEF; d_gnt stays 0.
- Byte-enable write: core write 0x000000AA to addr 5 with be=4'b0001 over 0xDEADBEEF → a read of addr 5 returns 0xDEADBEAA.
- Starvation, STARVE_MAX=4: c_req and d_req held high continuously → core granted 4 cycles, debug granted on cycle 5, core granted cycles 6-9, debug on 10; pattern repeats and starve_cnt never exceeds 4.
- Clear with ADDR_W=4: fill addrs 0-15 with 0x11111111, pulse clr_start → clr_busy high for exactly 16 cycles; m_addr steps 0..15; clr_done pulses once on cycle 17; reads of all 16 addrs return 0.
- Requests during clear: hold c_req=1 and d_req=1 through the clear → no grant while clr_busy is high; the first cycle after CLEAR grants the core (starve_cnt=0); a second clr_start mid-clear has no effect (still 16 cycles).
- Reset mid-clear: assert rst at clr_cnt=7 → next cycle clr_busy=0, clr_done never pulses, the FSM is in ARB; addrs 8-15 still read 0x11111111.
